// File: rtl/ce_rst_seq.sv
// Clock-enable dividers (optionally cascaded on the previous channel) plus in-order reset release and lock.
// Defining CE_RST_SEQ_SYNC_EN adds i_sync, which reloads all counters at once to phase-align the channels.
module ce_rst_seq #(
  parameter int N_CH      = 4,
  parameter int WIDTH_DIV = 16,
  parameter int RST_HOLD  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [N_CH*WIDTH_DIV-1:0] i_div,
  input  logic [N_CH-1:0]           i_cascade,
  input  logic                      i_div_load,
`ifdef CE_RST_SEQ_SYNC_EN
  input  logic                      i_sync,
`endif
  output logic [N_CH-1:0]           o_ce,
  output logic [N_CH-1:0]           o_rst_ch,
  output logic                      o_locked
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {ST_SEQ, ST_DONE} state_t;

  logic [WIDTH_DIV-1:0] r_cnt     [N_CH];
  logic [WIDTH_DIV-1:0] r_shd_div [N_CH];
  logic [N_CH-1:0]      r_shd_cas;
  logic [N_CH-1:0]      r_act_cas;
  logic [N_CH-1:0]      r_ce;
  logic [N_CH-1:0]      r_rst;
  logic                 r_locked;
  state_t               r_state;
  logic [SW-1:0]        r_stage;
  logic [HW-1:0]        r_hold;

  logic [WIDTH_DIV-1:0] w_nxt_div [N_CH];
  logic [N_CH-1:0]      w_nxt_cas;
  logic [N_CH-1:0]      w_evt;
  logic [N_CH-1:0]      w_reload;
  logic                 w_sync;

`ifdef CE_RST_SEQ_SYNC_EN
  assign w_sync = i_sync;
`else
  assign w_sync = 1'b0;
`endif

  // Divisor 0 behaves like 1: reload value is max(d,1)-1.
  function automatic logic [WIDTH_DIV-1:0] f_reload(input logic [WIDTH_DIV-1:0] d);
    return (d == '0) ? '0 : d - WIDTH_DIV'(1);
  endfunction

  // Channel 0 always counts clk; channel k>0 counts the registered ce of channel k-1 when cascaded.
  assign w_evt = ~(r_act_cas & ~N_CH'(1)) | (r_ce << 1);

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_nxt_div[k] = i_div_load ? i_div[k*WIDTH_DIV +: WIDTH_DIV] : r_shd_div[k];
      w_nxt_cas[k] = i_div_load ? i_cascade[k] : r_shd_cas[k];
      w_reload[k]  = w_evt[k] && (r_cnt[k] == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N_CH; k++) begin
        r_cnt[k]     <= f_reload(i_div[k*WIDTH_DIV +: WIDTH_DIV]);
        r_shd_div[k] <= i_div[k*WIDTH_DIV +: WIDTH_DIV];
      end
      r_shd_cas <= i_cascade;
      r_act_cas <= i_cascade;
      r_ce      <= '0;
    end else begin
      if (i_div_load) begin
        for (int k = 0; k < N_CH; k++) begin
          r_shd_div[k] <= i_div[k*WIDTH_DIV +: WIDTH_DIV];
        end
        r_shd_cas <= i_cascade;
      end
      // Shadow values take effect only at a reload (or sync), so periods are never cut short.
      for (int k = 0; k < N_CH; k++) begin
        if (w_sync || w_reload[k]) begin
          r_cnt[k]     <= f_reload(w_nxt_div[k]);
          r_act_cas[k] <= w_nxt_cas[k];
        end else if (w_evt[k]) begin
          r_cnt[k] <= r_cnt[k] - WIDTH_DIV'(1);
        end
      end
      r_ce <= w_sync ? '0 : w_reload;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= ST_SEQ;
      r_stage  <= '0;
      r_hold   <= '0;
      r_rst    <= '1;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_SEQ: begin
          if (r_ce[r_stage]) begin
            if (r_hold == HW'(RST_HOLD - 1)) begin
              r_rst[r_stage] <= 1'b0;
              r_hold         <= '0;
              if (r_stage == SW'(N_CH - 1)) begin
                r_state <= ST_DONE;
              end else begin
                r_stage <= r_stage + SW'(1);
              end
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
        end
        ST_DONE: begin
          r_locked <= 1'b1;
          r_rst    <= '0;
        end
        default: r_state <= ST_SEQ;
      endcase
    end
  end

  assign o_ce     = r_ce;
  assign o_rst_ch = r_rst;
  assign o_locked = r_locked;

endmodule

// File: tb/tb_ce_rst_seq.sv
// Directed bench for ce_rst_seq: divider timing, cascade, divisor reload, reset sequencing and restart.
module tb_ce_rst_seq;
  localparam int N_CH = 2;
  localparam int WD   = 16;
  localparam int RH   = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N_CH*WD-1:0]  div;
  logic [N_CH-1:0]     cascade;
  logic                div_load;
`ifdef CE_RST_SEQ_SYNC_EN
  logic                sync;
`endif
  logic [N_CH-1:0]     ce;
  logic [N_CH-1:0]     rst_ch;
  logic                locked;

  int n_total = 0;
  int n_bad   = 0;
  int edge_n  = 0;
  int t_c0a, t_c0b, t_c1a, t_c1b, t_r0, t_r1, t_lk, n_c0, n_c1;
  int q_c0[$];

  always #5 clk = ~clk;

  ce_rst_seq #(.N_CH(N_CH), .WIDTH_DIV(WD), .RST_HOLD(RH)) u_dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_div      (div),
    .i_cascade  (cascade),
    .i_div_load (div_load),
`ifdef CE_RST_SEQ_SYNC_EN
    .i_sync     (sync),
`endif
    .o_ce       (ce),
    .o_rst_ch   (rst_ch),
    .o_locked   (locked)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic set_div(input int d0, input int d1, input logic [1:0] cas);
    div     = {WD'(d1), WD'(d0)};
    cascade = cas;
  endtask

  task automatic do_reset(input string tag);
    reset_n  = 1'b0;
    div_load = 1'b0;
    tick();
    check({tag, ".rst_ce"}, int'(ce), 0);
    check({tag, ".rst_rstch"}, int'(rst_ch), 3);
    check({tag, ".rst_lock"}, int'(locked), 0);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic run_watch(input int budget);
    t_c0a = -1; t_c0b = -1; t_c1a = -1; t_c1b = -1;
    t_r0 = -1; t_r1 = -1; t_lk = -1; n_c0 = 0; n_c1 = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ce[0]) begin
        n_c0++;
        if (n_c0 == 1) t_c0a = edge_n;
        else if (n_c0 == 2) t_c0b = edge_n;
      end
      if (ce[1]) begin
        n_c1++;
        if (n_c1 == 1) t_c1a = edge_n;
        else if (n_c1 == 2) t_c1b = edge_n;
      end
      if (!rst_ch[0] && t_r0 < 0) t_r0 = edge_n;
      if (!rst_ch[1] && t_r1 < 0) t_r1 = edge_n;
      if (locked) begin
        t_lk = edge_n;
        break;
      end
    end
  endtask

  task automatic check_seq1(input string tag);
    run_watch(31000);
    check({tag, ".ce0_first"}, t_c0a, 250);
    check({tag, ".ce0_second"}, t_c0b, 500);
    check({tag, ".ce1_first"}, t_c1a, 7501);
    check({tag, ".ce1_second"}, t_c1b, 15001);
    check({tag, ".rst0_fall"}, t_r0, 1001);
    check({tag, ".rst1_fall"}, t_r1, 30002);
    check({tag, ".lock_rise"}, t_lk, 30003);
    check({tag, ".ce0_count"}, n_c0, 120);
    check({tag, ".ce1_count"}, n_c1, 4);
    check({tag, ".rst_final"}, int'(rst_ch), 0);
  endtask

  function automatic int q_at(input int i);
    return (q_c0.size() > i) ? q_c0[i] : -1;
  endfunction

  initial begin
    reset_n  = 1'b0;
    div_load = 1'b0;
`ifdef CE_RST_SEQ_SYNC_EN
    sync = 1'b0;
`endif

    // Cascaded 240 MHz -> 960 kHz -> 32 kHz chain and full reset sequence.
    set_div(250, 30, 2'b10);
    do_reset("s1");
    check_seq1("s1");

    // One-cycle reset after lock restarts with identical timing.
    do_reset("s5");
    check_seq1("s5");

    // Divisor 1 holds ce0 high; ch1 /3 uncascaded only counts once stage 1 is active.
    set_div(1, 3, 2'b00);
    do_reset("s2");
    run_watch(40);
    check("s2.ce0_first", t_c0a, 1);
    check("s2.ce0_second", t_c0b, 2);
    check("s2.rst0_fall", t_r0, RH + 1);
    check("s2.ce1_first", t_c1a, 3);
    check("s2.rst1_fall", t_r1, 16);
    check("s2.lock_rise", t_lk, 17);
    check("s2.ce0_count", n_c0, 17);
    check("s2.ce1_count", n_c1, 5);

    // Mid-period divisor change: current period finishes at 100, then 10.
    set_div(100, 1000, 2'b00);
    do_reset("s3");
    q_c0.delete();
    for (int i = 0; i < 330; i++) begin
      tick();
      if (ce[0]) q_c0.push_back(edge_n);
      div_load = (edge_n == 259);
      if (edge_n == 259) set_div(10, 1000, 2'b00);
    end
    check("s3.ce_a", q_at(0), 100);
    check("s3.ce_b", q_at(1), 200);
    check("s3.ce_c", q_at(2), 300);
    check("s3.ce_d", q_at(3), 310);
    check("s3.ce_e", q_at(4), 320);
    check("s3.ce_n", q_c0.size(), 6);
    begin
      int min_gap = 100000;
      for (int i = 1; i < q_c0.size(); i++) begin
        if (q_c0[i] - q_c0[i-1] < min_gap) min_gap = q_c0[i] - q_c0[i-1];
      end
      check("s3.min_gap", min_gap, 10);
    end

    // div_load sampled on the reload edge: the next period already uses the new divisor.
    set_div(20, 1000, 2'b00);
    do_reset("s4");
    q_c0.delete();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ce[0]) q_c0.push_back(edge_n);
      div_load = (edge_n == 39);
      if (edge_n == 39) set_div(7, 1000, 2'b00);
    end
    check("s4.ce_a", q_at(0), 20);
    check("s4.ce_b", q_at(1), 40);
    check("s4.ce_c", q_at(2), 47);
    check("s4.ce_d", q_at(3), 54);
    check("s4.ce_n", q_c0.size(), 4);

`ifdef CE_RST_SEQ_SYNC_EN
    begin
      int t_sync;
      int f0;
      int f1;
      t_sync = 100 + int'($urandom_range(1, 29));
      f0 = -1;
      f1 = -1;
      set_div(250, 30, 2'b00);
      do_reset("s6");
      while (edge_n < t_sync - 1) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("s6.ce_at_T", int'(ce), 0);
      tick();
      check("s6.ce_at_T1", int'(ce), 0);
      for (int i = 0; i < 300; i++) begin
        tick();
        if (ce[0] && f0 < 0) f0 = edge_n;
        if (ce[1] && f1 < 0) f1 = edge_n;
      end
      check("s6.ce0_after_sync", f0, t_sync + 250);
      check("s6.ce1_after_sync", f1, t_sync + 30);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
